mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Job sequencer for the int4×int8 double-MAC unit. It accepts a dot-product job (operand base address and pair count), reads operands from the operand buffer, and drives the MAC `pulse` and accumulator clear with the correct alignment. It captures the final accumulator value and returns it over a valid/ready result port. It sits between the job scheduler and one double-MAC unit plus its operand buffer.

## Interface
Parameters:
- `LEN_W`, 8: width of the job length (pulses per job).
- `ADDR_W`, 8: operand buffer address width.
- `ACC_W`, 26: accumulator/result width.

Ports:
- `clk`, input, 1: single clock; all logic on posedge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start_valid`, input, 1: job request.
- `start_ready`, output, 1: high only in IDLE.
- `start_len`, input, LEN_W: number of MAC pulses; 0 is legal.
- `start_base`, input, ADDR_W: first operand address.
- `hold`, input, 1: stalls operand issue while high.
- `rd_en`, output, 1: operand buffer read strobe; data returns 1 cycle later.
- `rd_addr`, output, ADDR_W: operand buffer read address.
- `mac_pulse`, output, 1: MAC pulse, aligned with returned read data.
- `mac_clr`, output, 1: accumulator clear; the accumulator zeroes at the end of the cycle in which this is high.
- `mac_result`, input, ACC_W: accumulator output (signed).
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: result consumer ready.
- `res_data`, output, ACC_W: registered signed result.
- `busy`, output, 1: high in any state except IDLE.

## Operation
- States and transitions:
  - **IDLE**: `start_ready`=1. On `start_valid`, latch `start_len` and `start_base`, clear the index, and go to CLEAR.
  - **CLEAR**: `mac_clr`=1 for exactly one cycle. Go to CAPTURE if len==0, else go to RUN.
  - **RUN**: `rd_en`=!hold and `rd_addr`=base+idx. When the read issues, idx increments. Go to DRAIN when the issue with idx==len-1 occurs.
  - **DRAIN**: one cycle. The last `mac_pulse` is asserted here.
  - **CAPTURE**: one cycle. `res_data` <= `mac_result`.
  - **DONE**: `res_valid`=1. On `res_ready`, go to IDLE.
- `mac_pulse` is `rd_en` registered by one cycle. Pulses therefore follow hold gaps exactly.
- `rd_addr` is base+idx modulo 2^ADDR_W. It wraps silently.
- `hold` is ignored outside RUN.
- The block never asserts `mac_clr` and `mac_pulse` in the same cycle.
- `res_data` is held stable from CAPTURE until the next CAPTURE.
- A new job is never accepted in the cycle its predecessor's result is consumed. The block accepts it at the earliest one cycle later, in IDLE.
- Reset (any state): go to IDLE, idx=0. All outputs read 0 except `start_ready`=1. `res_data`=0.
- Reset mid-job discards the job. The MAC accumulator is not cleared by this block on reset; the next job's CLEAR handles it.

## Timing
- Start accepted at edge S. Then:
  - CLEAR in cycle S+1.
  - First `rd_en` in S+2.
  - With no hold, RUN covers S+2..S+1+N.
  - DRAIN in S+2+N.
  - CAPTURE in S+3+N.
  - `res_valid` from S+4+N.
- Each hold cycle in RUN adds exactly one cycle to everything after it.
- N=0: CLEAR in S+1, CAPTURE in S+2, `res_valid` in S+3 with `res_data`=0.
- Throughput: back-to-back jobs with `res_ready` tied high take N+5 cycles each.

## Configuration
- `MAC_SEQ_STALL_CNT_EN` defined: adds output `stall_cnt` (16 bits).
  - Counts cycles in RUN with `hold`=1.
  - Clears on start acceptance and saturates at 0xFFFF.
  - Holds its value until the next start. Resets to 0.
- `MAC_SEQ_STALL_CNT_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- **Basic job**: base=0x10, N=4. Buffer holds a=(1,2),(−1,3),(7,−8),(0,5) and b=(10,20),(−128,4),(127,1),(9,9) per lane.
  - `rd_addr` = 0x10..0x13 in S+2..S+5.
  - `mac_pulse` in S+3..S+6.
  - `res_valid` at S+8 with `res_data` = 50+140+881+45 = 1116.
- **Zero length**: N=0.
  - No `rd_en` and no `mac_pulse`.
  - `mac_clr` in S+1.
  - `res_valid` at S+3 with `res_data`=0.
- **Hold stall**: N=3 with `hold`=1 in S+3 and S+4.
  - Addresses issue in S+2, S+5, S+6.
  - `mac_pulse` in S+3, S+6, S+7.
  - `res_valid` at S+9.
  - With the macro defined, `stall_cnt`=2.
- **Result backpressure**: `res_ready`=0 for 5 cycles after `res_valid` rises.
  - `res_valid` and `res_data` stay stable.
  - `start_ready`=0 throughout.
  - The job is accepted the cycle after IDLE is re-entered.
- **Wrap**: base=0xFE, N=4.
  - `rd_addr` sequence is 0xFE, 0xFF, 0x00, 0x01.
- **Reset mid-RUN**: assert `reset` at idx=2 of N=6.
  - Outputs go to reset values immediately.
  - A following job with N=1 yields `mac_clr` before its pulse, and the correct single-pair result.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for one int4 x int8 double-MAC unit and its operand buffer.
// Optional stall counter output enabled by MAC_SEQ_STALL_CNT_EN. Rev 1.0
`default_nettype none

module mac_seq_ctrl #(
   parameter int LEN_W  = 8,
   parameter int ADDR_W = 8,
   parameter int ACC_W  = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [LEN_W-1:0]  start_len,
   input  logic [ADDR_W-1:0] start_base,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              mac_pulse,
   output logic              mac_clr,
   input  logic [ACC_W-1:0]  mac_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
`ifdef MAC_SEQ_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              busy
);

   localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_RUN     = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ACC_W-1:0]  res_q, res_d;
   logic              pulse_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         base_q  <= '0;
         res_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         res_q   <= res_d;
         pulse_q <= rd_en;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      base_d      = base_q;
      res_d       = res_q;
      start_ready = 1'b0;
      busy        = 1'b1;
      mac_clr     = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = '0;
      res_valid   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               len_d   = start_len;
               base_d  = start_base;
               idx_d   = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            mac_clr = 1'b1;
            state_d = (len_q == '0) ? ST_CAPTURE : ST_RUN;
         end
         ST_RUN: begin
            rd_en   = !hold;
            rd_addr = base_q + ADDR_W'(idx_q);
            if (!hold) begin
               idx_d = idx_q + c_LEN_ONE;
               if (idx_q == len_q - c_LEN_ONE) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Last pulse lands here; the accumulator is final one cycle later.
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            res_d   = mac_result;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mac_pulse = pulse_q;
   assign res_data  = res_q;

`ifdef MAC_SEQ_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == ST_IDLE && start_valid) begin
         stall_d = '0;
      end else if (state_q == ST_RUN && hold && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed jobs against a cycle-schedule model of mac_seq_ctrl with an operand buffer and MAC.
`default_nettype none

module tb_mac_seq_ctrl;

   localparam int MAXC = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_valid;
   logic        start_ready;
   logic [7:0]  start_len;
   logic [7:0]  start_base;
   logic        hold;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic        mac_pulse;
   logic        mac_clr;
   logic [25:0] mac_result;
   logic        res_valid;
   logic        res_ready;
   logic [25:0] res_data;
   logic        busy;
`ifdef MAC_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   mac_seq_ctrl #(.LEN_W(8), .ADDR_W(8), .ACC_W(26)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .start_len   (start_len),
      .start_base  (start_base),
      .hold        (hold),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .mac_pulse   (mac_pulse),
      .mac_clr     (mac_clr),
      .mac_result  (mac_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
`ifdef MAC_SEQ_STALL_CNT_EN
      .stall_cnt   (stall_cnt),
`endif
      .busy        (busy)
   );

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // operand buffer: per-address lane pairs a=(a0,a1) int4, b=(b0,b1) int8
   logic signed [3:0] ma0 [256];
   logic signed [3:0] ma1 [256];
   logic signed [7:0] mb0 [256];
   logic signed [7:0] mb1 [256];

   function automatic int dot(input int a);
      return int'(ma0[a]) * int'(mb0[a]) + int'(ma1[a]) * int'(mb1[a]);
   endfunction

   // environment: buffer returns data one cycle after rd_en, MAC accumulates on pulse
   int rd_q = 0;
   int acc  = 0;
   always @(posedge clk) begin
      if (rd_en) rd_q <= int'(rd_addr);
      if (mac_clr) acc <= 0;
      else if (mac_pulse) acc <= acc + dot(rd_q);
   end
   assign mac_result = acc[25:0];

   // expected outputs per cycle
   bit          e_sr    [MAXC];
   bit          e_busy  [MAXC];
   bit          e_clr   [MAXC];
   bit          e_rd    [MAXC];
   logic [7:0]  e_addr  [MAXC];
   bit          e_pulse [MAXC];
   bit          e_valid [MAXC];
   logic [25:0] e_res   [MAXC];

   // observed outputs per cycle
   bit          o_sr    [MAXC];
   bit          o_clr   [MAXC];
   bit          o_rd    [MAXC];
   logic [7:0]  o_addr  [MAXC];
   bit          o_pulse [MAXC];
   bit          o_valid [MAXC];
   logic [25:0] o_res   [MAXC];

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         o_sr[cyc]    <= start_ready;
         o_clr[cyc]   <= mac_clr;
         o_rd[cyc]    <= rd_en;
         o_addr[cyc]  <= rd_addr;
         o_pulse[cyc] <= mac_pulse;
         o_valid[cyc] <= res_valid;
         o_res[cyc]   <= res_data;
         chk("start_ready", cyc, 32'(start_ready), 32'(e_sr[cyc]));
         chk("busy",        cyc, 32'(busy),        32'(e_busy[cyc]));
         chk("mac_clr",     cyc, 32'(mac_clr),     32'(e_clr[cyc]));
         chk("rd_en",       cyc, 32'(rd_en),       32'(e_rd[cyc]));
         chk("mac_pulse",   cyc, 32'(mac_pulse),   32'(e_pulse[cyc]));
         chk("res_valid",   cyc, 32'(res_valid),   32'(e_valid[cyc]));
         chk("res_data",    cyc, 32'(res_data),    32'(e_res[cyc]));
         if (e_rd[cyc]) chk("rd_addr", cyc, 32'(rd_addr), 32'(e_addr[cyc]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plans the full expected schedule of one job from its parameters, then drives it.
   // mask bit j = hold driven in cycle a+j; dly = cycles res_ready stays low after res_valid rises.
   task automatic run_job(input logic [7:0] base, input int n, input int mask, input int dly,
                          input bit early, input logic [7:0] nb, input int nn,
                          output int a_o, output int v_o);
      int a, t, tl, v, sum;
      a   = cyc;
      t   = a + 2;
      tl  = a + 1;
      sum = 0;
      for (int k = 0; k < n; k++) begin
         while ((t - a) < 32 && mask[t - a]) t++;
         e_rd[t]      = 1'b1;
         e_addr[t]    = base + 8'(k);
         e_pulse[t+1] = 1'b1;
         sum          = sum + dot(int'(base + 8'(k)));
         tl           = t;
         t++;
      end
      v = (n == 0) ? a + 3 : tl + 3;
      for (int c = a + 1; c <= v + dly; c++) begin
         e_sr[c]   = 1'b0;
         e_busy[c] = 1'b1;
      end
      e_clr[a+1] = 1'b1;
      for (int c = v; c <= v + dly; c++) e_valid[c] = 1'b1;
      for (int c = v; c < MAXC; c++) e_res[c] = 26'(sum);

      start_valid = 1'b1;
      start_base  = base;
      start_len   = n[7:0];
      hold        = mask[0];
      res_ready   = 1'b0;
      for (int c = a + 1; c <= v + dly; c++) begin
         step();
         start_valid = early && (c >= v);
         start_base  = nb;
         start_len   = nn[7:0];
         hold        = ((c - a) < 32) ? mask[c - a] : 1'b0;
         res_ready   = (c >= v + dly);
`ifdef MAC_SEQ_STALL_CNT_EN
         if (c == v) chk("stall_cnt", c, 32'(stall_cnt), (n == 0) ? 32'd0 : 32'(tl - a - 1 - n));
`endif
      end
      step();
      start_valid = early;
      hold        = 1'b0;
      res_ready   = 1'b0;
      a_o = a;
      v_o = v;
   endtask

   initial begin
      int a, v, a2, v2, ra;
      logic [7:0] wrap_exp [4];

      for (int i = 0; i < 256; i++) begin
         ma0[i] = 4'(i);
         ma1[i] = 4'(i * 7 + 3);
         mb0[i] = 8'(i * 37 + 5);
         mb1[i] = 8'(i * 91 + 11);
      end
      ma0[8'h10] = 4'sd1;  ma1[8'h10] = 4'sd2;  mb0[8'h10] = 8'sd10;   mb1[8'h10] = 8'sd20;
      ma0[8'h11] = -4'sd1; ma1[8'h11] = 4'sd3;  mb0[8'h11] = -8'sd128; mb1[8'h11] = 8'sd4;
      ma0[8'h12] = 4'sd7;  ma1[8'h12] = -4'sd8; mb0[8'h12] = 8'sd127;  mb1[8'h12] = 8'sd1;
      ma0[8'h13] = 4'sd0;  ma1[8'h13] = 4'sd5;  mb0[8'h13] = 8'sd9;    mb1[8'h13] = 8'sd9;

      for (int c = 0; c < MAXC; c++) begin
         e_sr[c] = 1'b1; e_busy[c] = 1'b0; e_clr[c] = 1'b0; e_rd[c] = 1'b0;
         e_addr[c] = 8'h00; e_pulse[c] = 1'b0; e_valid[c] = 1'b0; e_res[c] = 26'd0;
      end

      reset = 1'b1; start_valid = 1'b0; start_len = 8'd0; start_base = 8'd0;
      hold = 1'b0; res_ready = 1'b0;
      repeat (3) step();
      chk("reset rd_addr", cyc, 32'(rd_addr), 32'h0);
`ifdef MAC_SEQ_STALL_CNT_EN
      chk("reset stall_cnt", cyc, 32'(stall_cnt), 32'h0);
`endif
      reset = 1'b0;

      // basic job
      run_job(8'h10, 4, 0, 0, 1'b0, 8'h00, 0, a, v);
      for (int k = 0; k < 4; k++) begin
         chk("basic addr",  a + 2 + k, 32'(o_addr[a+2+k]), 32'(8'h10 + 8'(k)));
         chk("basic pulse", a + 3 + k, 32'(o_pulse[a+3+k]), 32'd1);
      end
      chk("basic valid early", a + 7, 32'(o_valid[a+7]), 32'd0);
      chk("basic valid",       a + 8, 32'(o_valid[a+8]), 32'd1);
      chk("basic result",      a + 8, 32'(o_res[a+8]), 32'(26'd1116));

      // zero-length job
      run_job(8'h40, 0, 0, 0, 1'b0, 8'h00, 0, a, v);
      chk("zero clr",   a + 1, 32'(o_clr[a+1]), 32'd1);
      chk("zero rd",    a + 2, 32'(o_rd[a+1] | o_rd[a+2] | o_rd[a+3]), 32'd0);
      chk("zero pulse", a + 2, 32'(o_pulse[a+1] | o_pulse[a+2] | o_pulse[a+3]), 32'd0);
      chk("zero valid", a + 3, 32'(o_valid[a+3]), 32'd1);
      chk("zero res",   a + 3, 32'(o_res[a+3]), 32'd0);

      // hold stall in S+3,S+4; holds in CLEAR and DRAIN must be ignored
      run_job(8'h20, 3, (1 << 1) | (1 << 3) | (1 << 4) | (1 << 7), 0, 1'b0, 8'h00, 0, a, v);
      chk("hold rd S+2",    a + 2, 32'(o_rd[a+2]), 32'd1);
      chk("hold rd S+3",    a + 3, 32'(o_rd[a+3]), 32'd0);
      chk("hold rd S+5",    a + 5, 32'(o_rd[a+5]), 32'd1);
      chk("hold addr S+6",  a + 6, 32'(o_addr[a+6]), 32'h22);
      chk("hold pulse S+6", a + 6, 32'(o_pulse[a+6]), 32'd1);
      chk("hold pulse S+7", a + 7, 32'(o_pulse[a+7]), 32'd1);
      chk("hold valid S+8", a + 8, 32'(o_valid[a+8]), 32'd0);
      chk("hold valid S+9", a + 9, 32'(o_valid[a+9]), 32'd1);

      // result backpressure with the next job already requested
      run_job(8'h30, 2, 0, 5, 1'b1, 8'h50, 3, a, v);
      for (int c = v; c <= v + 5; c++) begin
         chk("bp start_ready", c, 32'(o_sr[c]), 32'd0);
         chk("bp res stable",  c, 32'(o_res[c]), 32'(o_res[v]));
      end
      run_job(8'h50, 3, 0, 0, 1'b0, 8'h00, 0, a2, v2);
      chk("bp next clr", v + 7, 32'(o_clr[v+7]), 32'd1);

      // back-to-back throughput, N+5 cycles per job
      run_job(8'h70, 2, 0, 0, 1'b0, 8'h00, 0, a, v);
      run_job(8'h80, 2, 0, 0, 1'b0, 8'h00, 0, a2, v2);
      chk("b2b valid",      a + 6, 32'(o_valid[a+6]), 32'd1);
      chk("b2b second clr", a + 8, 32'(o_clr[a+8]), 32'd1);

      // address wrap
      wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
      run_job(8'hFE, 4, 0, 0, 1'b0, 8'h00, 0, a, v);
      for (int k = 0; k < 4; k++) chk("wrap addr", a + 2 + k, 32'(o_addr[a+2+k]), 32'(wrap_exp[k]));

      // reset in RUN at idx=2 of a 6-pair job
      ra = cyc;
      for (int c = ra + 1; c <= ra + 3; c++) begin
         e_sr[c] = 1'b0; e_busy[c] = 1'b1;
      end
      e_clr[ra+1] = 1'b1;
      e_rd[ra+2] = 1'b1; e_addr[ra+2] = 8'h60;
      e_rd[ra+3] = 1'b1; e_addr[ra+3] = 8'h61;
      e_pulse[ra+3] = 1'b1;
      for (int c = ra + 4; c < MAXC; c++) e_res[c] = 26'd0;
      start_valid = 1'b1; start_base = 8'h60; start_len = 8'd6;
      step();
      start_valid = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("post-reset rd", ra + 4, 32'(o_rd[ra+4]), 32'd0);
      chk("post-reset sr", ra + 4, 32'(o_sr[ra+4]), 32'd1);
`ifdef MAC_SEQ_STALL_CNT_EN
      chk("post-reset stall_cnt", cyc, 32'(stall_cnt), 32'h0);
`endif
      run_job(8'h13, 1, 0, 0, 1'b0, 8'h00, 0, a, v);
      chk("after reset clr",    a + 1, 32'(o_clr[a+1]), 32'd1);
      chk("after reset pulse",  a + 3, 32'(o_pulse[a+3]), 32'd1);
      chk("after reset result", v, 32'(o_res[v]), 32'(26'd45));

      repeat (4) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
